// File: rtl/cnn_layer_accel_weight_loader.sv
// Weight loader: parses a kernel-count header from a 16-bit config stream and
// writes 9 weights per 3x3 kernel into the CE weight table.
module cnn_layer_accel_weight_loader #(
    parameter int C_KERNEL_COUNT = 9,
    parameter int C_MAX_KERNELS  = 64,
    parameter int C_WORD_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_start,
    input  logic                    abort,
    input  logic                    cfg_in_valid,
    output logic                    cfg_in_ready,
    input  logic [C_WORD_WIDTH-1:0] cfg_in_data,
    input  logic                    cfg_in_last,
    output logic                    job_accept,
    output logic                    config_mode,
    output logic                    kernel_config_valid,
    output logic [C_WORD_WIDTH-1:0] num_kernels,
    output logic                    wht_config_wren,
    output logic [C_WORD_WIDTH-1:0] wht_config_data,
    output logic                    load_done,
    output logic                    load_error,
    output logic                    busy
);

    localparam int WHT_W = $clog2(C_KERNEL_COUNT);
    localparam int KRN_W = $clog2(C_MAX_KERNELS);
    localparam logic [WHT_W-1:0]        WHT_LAST = WHT_W'(C_KERNEL_COUNT - 1);
    localparam logic [C_WORD_WIDTH-1:0] HDR_MAX  = C_WORD_WIDTH'(C_MAX_KERNELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t           state;
    logic [WHT_W-1:0] wht_cnt;
    logic [KRN_W-1:0] krn_cnt;
    logic             xfer;
    logic             final_word;

    // abort blocks acceptance of a word presented in the same cycle
    assign cfg_in_ready = ((state == ST_HDR) || (state == ST_LOAD)) && !abort;
    assign busy         = (state != ST_IDLE);
    assign xfer         = cfg_in_valid && cfg_in_ready;
    assign final_word   = (wht_cnt == WHT_LAST) && (krn_cnt == num_kernels[KRN_W-1:0]);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_IDLE;
            wht_cnt             <= '0;
            krn_cnt             <= '0;
            job_accept          <= 1'b0;
            config_mode         <= 1'b0;
            kernel_config_valid <= 1'b0;
            num_kernels         <= '0;
            wht_config_wren     <= 1'b0;
            wht_config_data     <= '0;
            load_done           <= 1'b0;
            load_error          <= 1'b0;
        end else begin
            job_accept          <= 1'b0;
            kernel_config_valid <= 1'b0;
            wht_config_wren     <= 1'b0;
            load_done           <= 1'b0;

            if (abort) begin
                state       <= ST_IDLE;
                config_mode <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_ERR: begin
                        config_mode <= 1'b0;
                        if (job_start) begin
                            job_accept <= 1'b1;
                            wht_cnt    <= '0;
                            krn_cnt    <= '0;
                            load_error <= 1'b0;
                            state      <= ST_HDR;
                        end
                    end

                    ST_HDR: begin
                        if (xfer) begin
                            if ((cfg_in_data > HDR_MAX) || cfg_in_last) begin
                                load_error <= 1'b1;
                                state      <= ST_ERR;
                            end else begin
                                num_kernels         <= cfg_in_data;
                                kernel_config_valid <= 1'b1;
                                config_mode         <= 1'b1;
                                state               <= ST_LOAD;
                            end
                        end
                    end

                    ST_LOAD: begin
                        if (xfer) begin
                            wht_config_wren <= 1'b1;
                            wht_config_data <= cfg_in_data;
                            if (wht_cnt == WHT_LAST) begin
                                wht_cnt <= '0;
                                krn_cnt <= krn_cnt + 1'b1;
                            end else begin
                                wht_cnt <= wht_cnt + 1'b1;
                            end
                            // Final word with last finishes; a missing or
                            // early last is a framing error.
                            if (final_word && cfg_in_last) begin
                                state <= ST_DONE;
                            end else if (final_word || cfg_in_last) begin
                                load_error  <= 1'b1;
                                config_mode <= 1'b0;
                                state       <= ST_ERR;
                            end
                        end
                    end

                    ST_DONE: begin
                        // config_mode was held through the final write cycle
                        config_mode <= 1'b0;
                        load_done   <= 1'b1;
                        state       <= ST_IDLE;
                    end

                    default: begin
                        config_mode <= 1'b0;
                        state       <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
// Bench for the weight loader: table-driven load cases with a write scoreboard,
// plus hand-written abort and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_cnn_layer_accel_weight_loader;

    logic        clk;
    logic        rst;
    logic        job_start;
    logic        abort;
    logic        cfg_in_valid;
    logic        cfg_in_ready;
    logic [15:0] cfg_in_data;
    logic        cfg_in_last;
    logic        job_accept;
    logic        config_mode;
    logic        kernel_config_valid;
    logic [15:0] num_kernels;
    logic        wht_config_wren;
    logic [15:0] wht_config_data;
    logic        load_done;
    logic        load_error;
    logic        busy;

    cnn_layer_accel_weight_loader dut (
        .clk                 (clk),
        .rst                 (rst),
        .job_start           (job_start),
        .abort               (abort),
        .cfg_in_valid        (cfg_in_valid),
        .cfg_in_ready        (cfg_in_ready),
        .cfg_in_data         (cfg_in_data),
        .cfg_in_last         (cfg_in_last),
        .job_accept          (job_accept),
        .config_mode         (config_mode),
        .kernel_config_valid (kernel_config_valid),
        .num_kernels         (num_kernels),
        .wht_config_wren     (wht_config_wren),
        .wht_config_data     (wht_config_data),
        .load_done           (load_done),
        .load_error          (load_error),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hdr;
        int          nwords;
        int          last_at;   // 0 = never assert last
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
        int          exp_wr;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_wren   = 0;
    int          n_done   = 0;
    logic [15:0] exp_nk   = '0;
    logic [15:0] sb[$];
    vec_t        tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at the negedge: pops the scoreboard for every observed write.
    task automatic sample_outputs();
        if (wht_config_wren) begin
            n_wren++;
            if (sb.size() == 0) check("wren_unexpected", 32'(sb.size()), 1);
            else check("wren_data", wht_config_data, sb.pop_front());
        end
        if (load_done) n_done++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample_outputs();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [15:0] d, input logic l, input bit push);
        bit ok;
        ok           = 1'b0;
        cfg_in_valid = 1'b1;
        cfg_in_data  = d;
        cfg_in_last  = l;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            sample_outputs();
            if (cfg_in_ready) begin
                ok = 1'b1;
                if (push) sb.push_back(d);
            end
            @(posedge clk);
            #1;
        end
        cfg_in_valid = 1'b0;
        cfg_in_last  = 1'b0;
        if (!ok) check("xfer_timeout", 0, 1);
    endtask

    task automatic start_job();
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        check("job_accept", job_accept, 1);
        check("start_err_clr", load_error, 0);
        check("start_busy", busy, 1);
    endtask

    task automatic run_case(input vec_t v);
        int base_w;
        int base_d;
        base_w = n_wren;
        base_d = n_done;
        start_job();
        xfer(v.hdr, 1'b0, 1'b0);
        check("job_accept_pulse", job_accept, 0);
        if (v.hdr > 16'd63) begin
            check("rng_err", load_error, 1);
            check("rng_nk_kept", num_kernels, exp_nk);
            check("rng_kcv", kernel_config_valid, 0);
            check("rng_ready", cfg_in_ready, 0);
            check("rng_cfg_mode", config_mode, 0);
        end else begin
            exp_nk = v.hdr;
            check("kcv", kernel_config_valid, 1);
            check("num_kernels", num_kernels, exp_nk);
            check("cfg_mode_on", config_mode, 1);
        end
        for (int w = 1; w <= v.nwords; w++) begin
            if (v.gaps && $urandom_range(0, 1) == 1) tick();
            xfer(16'h0100 + 16'(w), w == v.last_at, 1'b1);
        end
        if (v.nwords > 0) begin
            if (v.exp_done) begin
                check("final_wren", wht_config_wren, 1);
                check("final_cfg_mode", config_mode, 1);
                tick();
                check("load_done", load_done, 1);
                check("done_cfg_mode", config_mode, 0);
                check("done_busy", busy, 0);
            end else begin
                check("frm_err", load_error, 1);
                check("frm_ready", cfg_in_ready, 0);
                check("frm_cfg_mode", config_mode, 0);
                check("frm_busy", busy, 1);
            end
        end
        repeat (3) tick();
        check("wren_count", n_wren - base_w, v.exp_wr);
        check("done_count", n_done - base_d, 32'(v.exp_done));
        check("sb_drained", sb.size(), 0);
        check("err_final", load_error, 32'(v.exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            hdr       nw   last gaps done err  writes
        tbl[0] = '{16'd0,      9,   9,   0,   1,   0,   9};
        tbl[1] = '{16'd2,      27,  27,  1,   1,   0,   27};
        tbl[2] = '{16'd64,     0,   0,   0,   0,   1,   0};
        tbl[3] = '{16'd1,      5,   5,   1,   0,   1,   5};
        tbl[4] = '{16'd1,      18,  0,   0,   0,   1,   18};
        tbl[5] = '{16'hFFFF,   0,   0,   0,   0,   1,   0};

        rst          = 1'b0;
        job_start    = 1'b0;
        abort        = 1'b0;
        cfg_in_valid = 1'b0;
        cfg_in_data  = '0;
        cfg_in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {job_accept, config_mode, kernel_config_valid, wht_config_wren,
                              load_done, load_error, busy, cfg_in_ready}, 0);
        check("rst_nk", num_kernels, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) run_case(tbl[i]);

        // Maximum-size load with 50% valid gaps
        run_case('{16'd63, 576, 576, 1, 1, 0, 576});

        // Abort on the same edge as the 4th LOAD transfer
        begin
            int base_w;
            base_w = n_wren;
            start_job();
            xfer(16'd1, 1'b0, 1'b0);
            exp_nk = 16'd1;
            for (int w = 1; w <= 3; w++) xfer(16'h0A00 + 16'(w), 1'b0, 1'b1);
            cfg_in_valid = 1'b1;
            cfg_in_data  = 16'h0A04;
            abort        = 1'b1;
            @(negedge clk);
            sample_outputs();
            check("abort_ready", cfg_in_ready, 0);
            @(posedge clk);
            #1;
            abort        = 1'b0;
            cfg_in_valid = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_cfg_mode", config_mode, 0);
            check("abort_wren", wht_config_wren, 0);
            repeat (2) tick();
            check("abort_wren_count", n_wren - base_w, 3);
            check("abort_sb", sb.size(), 0);
            check("abort_err_kept", load_error, 0);
        end

        // Asynchronous reset in the middle of a load
        start_job();
        xfer(16'd2, 1'b0, 1'b0);
        exp_nk = 16'd2;
        for (int w = 1; w <= 4; w++) xfer(16'h0B00 + 16'(w), 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_outputs", {job_accept, config_mode, kernel_config_valid, wht_config_wren,
                               load_done, load_error, busy, cfg_in_ready}, 0);
        check("arst_nk", num_kernels, 0);
        check("arst_wdata", wht_config_data, 0);
        sb.delete();
        exp_nk = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();
        check("arst_idle", busy, 0);
        run_case(tbl[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
